bus_addr_reg: RTL

16-bit address register loaded from the 8-bit data bus, the receiving end of the bus that the register set drives through its tri-state transmitter. It captures address bytes from the bus, either by explicit low/high strobes or by a two-step byte sequencer. It supports post-increment for sequential memory access and presents a stable address to the memory and program-counter logic.

---
 rtl/bus_addr_reg.sv | 99 +++++++++
 1 files changed

// File: rtl/bus_addr_reg.sv
// bus_addr_reg: 16-bit address register fed from the 8-bit data bus.
// Bytes arrive by explicit low/high strobes or through a two-step byte
// sequencer. The register can post-increment for sequential memory access.
// Every output is a register, so the address seen by memory and PC logic
// is stable for the whole cycle.
module bus_addr_reg #(
   parameter logic [15:0] RESET_ADDR = 16'h0000
) (
   input  logic        i_clk,
   input  logic        i_nReset,
   input  logic [7:0]  i_bus,
   input  logic        i_loadLo,
   input  logic        i_loadHi,
   input  logic        i_loadSeq,
   input  logic        i_inc,
   output logic [15:0] o_addr,
   output logic        o_hiNext,
   output logic        o_wrap
);

   // Sequencer: which byte the next i_loadSeq writes.
   typedef enum logic {
      LO_NEXT = 1'b0,
      HI_NEXT = 1'b1
   } seq_state_e;

   seq_state_e  seq_q, seq_d;
   logic [15:0] addr_q, addr_d;
   logic        wrap_q, wrap_d;

   // Command decode. Explicit loads override the sequencer, and any load
   // overrides the increment.
   logic explicit_load;
   logic seq_load;
   logic inc_en;

   assign explicit_load = i_loadLo | i_loadHi;
   assign seq_load      = i_loadSeq & ~explicit_load;
   assign inc_en        = i_inc & ~explicit_load & ~i_loadSeq;

   // State registers. Reset is asynchronous, so a reset during HI_NEXT
   // returns to LO_NEXT at once, without waiting for a clock edge.
   always_ff @(posedge i_clk or negedge i_nReset) begin
      if (!i_nReset) begin
         addr_q <= RESET_ADDR;
         seq_q  <= LO_NEXT;
         wrap_q <= 1'b0;
      end else begin
         addr_q <= addr_d;
         seq_q  <= seq_d;
         wrap_q <= wrap_d;
      end
   end

   // Next-state logic. Everything holds by default, and the wrap flag
   // falls back to 0 unless this edge performs a wrapping increment.
   always_comb begin
      addr_d = addr_q;
      seq_d  = seq_q;
      wrap_d = 1'b0;

      if (explicit_load) begin
         // Loads replace bytes exactly as they appear on the bus, with no
         // carry into the other byte. When both strobes are set, the same
         // bus byte goes into both halves.
         if (i_loadLo) begin
            addr_d[7:0] = i_bus;
         end
         if (i_loadHi) begin
            addr_d[15:8] = i_bus;
         end
         // A fresh explicit address cancels any half-finished byte pair.
         seq_d = LO_NEXT;
      end else if (seq_load) begin
         unique case (seq_q)
            LO_NEXT: begin
               addr_d[7:0] = i_bus;
               seq_d       = HI_NEXT;
            end
            HI_NEXT: begin
               addr_d[15:8] = i_bus;
               seq_d        = LO_NEXT;
            end
            default: begin
               seq_d = LO_NEXT;
            end
         endcase
      end else if (inc_en) begin
         // Post-increment modulo 2^16. The sequencer is not affected.
         addr_d = addr_q + 16'd1;
         wrap_d = (addr_q == 16'hFFFF);
      end
   end

   assign o_addr   = addr_q;
   assign o_hiNext = (seq_q == HI_NEXT);
   assign o_wrap   = wrap_q;

endmodule
